// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin, burst-locking arbiter feeding the source side of a CDC FIFO; beats are tagged with the owner index.
// Optional statistics (stall counter, handshake checker) are enabled by defining CDC_FIFO_ARB_STATS_EN.

module cdc_fifo_src_arb_lane #(
    parameter int IdxW = 2,
    parameter int K    = 0
) (
    input  logic            granted,
    input  logic [IdxW-1:0] sel,
    input  logic            fifo_ready,
    output logic            ready
);
    assign ready = granted && (sel == IdxW'(K)) && fifo_ready;
endmodule

module cdc_fifo_src_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 8,
    localparam int IdxW      = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [IdxW+WIDTH-1:0]    fifo_data_o,
    output logic                     fifo_valid_o,
    input  logic                     fifo_ready_i,
    output logic [IdxW-1:0]          grant_idx_o,
    output logic                     busy_o
`ifdef CDC_FIFO_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt_o,
    output logic                     handshake_err_o
`endif
);
    localparam int CntW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] sel_q;
    logic [CntW-1:0] beat_cnt;

    logic             granted;
    logic             owner_valid;
    logic             owner_last;
    logic [WIDTH-1:0] owner_data;
    logic             beat;
    logic             release_beat;
    logic             arb_found;
    logic [IdxW-1:0]  arb_idx;
    logic [IdxW-1:0]  cand;

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IdxW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign granted      = (state == GRANT);
    assign owner_valid  = req_valid_i[sel_q];
    assign owner_last   = req_last_i[sel_q];
    assign owner_data   = req_data_i[sel_q*WIDTH +: WIDTH];

    assign fifo_valid_o = granted && owner_valid;
    assign fifo_data_o  = granted ? {sel_q, owner_data} : '0;
    assign grant_idx_o  = granted ? sel_q : '0;
    assign busy_o       = granted;

    assign beat         = fifo_valid_o && fifo_ready_i;
    assign release_beat = beat && (owner_last || beat_cnt == CntW'(MAX_BURST - 1));

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        cdc_fifo_src_arb_lane #(
            .IdxW (IdxW),
            .K    (k)
        ) u_lane (
            .granted    (granted),
            .sel        (sel_q),
            .fifo_ready (fifo_ready_i),
            .ready      (req_ready_o[k])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sel_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        sel_q    <= arb_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A valid gap or full FIFO simply holds the grant with the count frozen.
                    if (beat) begin
                        beat_cnt <= beat_cnt + CntW'(1);
                        if (release_beat) begin
                            state  <= IDLE;
                            rr_ptr <= (sel_q == IdxW'(NUM_REQ - 1)) ? '0 : sel_q + IdxW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CDC_FIFO_ARB_STATS_EN
    logic             stalled;
    logic             stall_q;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    assign stalled = fifo_valid_o && !fifo_ready_i;

    // A cycle following a stall must present the identical beat with valid still high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o     <= '0;
            handshake_err_o <= 1'b0;
            stall_q         <= 1'b0;
            prev_data       <= '0;
            prev_last       <= 1'b0;
        end else begin
            if (stalled && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (stall_q && granted &&
                (!owner_valid || owner_data != prev_data || owner_last != prev_last))
                handshake_err_o <= 1'b1;
            stall_q   <= stalled;
            prev_data <= owner_data;
            prev_last <= owner_last;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed, table-driven bench for cdc_fifo_src_arbiter (NUM_REQ=4, WIDTH=32, MAX_BURST=8).
module tb_cdc_fifo_src_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [IW+W-1:0]   fifo_data;
    logic              fifo_valid;
    logic              fifo_ready;
    logic [IW-1:0]     grant_idx;
    logic              busy;
`ifdef CDC_FIFO_ARB_STATS_EN
    logic [15:0]       stall_cnt;
    logic              hs_err;
`endif

    int total = 0;
    int bad   = 0;

    cdc_fifo_src_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .fifo_data_o  (fifo_data),
        .fifo_valid_o (fifo_valid),
        .fifo_ready_i (fifo_ready),
        .grant_idx_o  (grant_idx),
        .busy_o       (busy)
`ifdef CDC_FIFO_ARB_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .handshake_err_o (hs_err)
`endif
    );

    always #5 clk = ~clk;

    // exp = {fifo_valid, fifo_data, req_ready, busy, grant_idx}
    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        fr;
        logic [23:0] pay;
        logic [41:0] exp;
    } vec_t;

    // Every requester k presents {k, pay}; eg<0 means the arbiter should be idle.
    function automatic vec_t mk(logic [3:0] vld, logic [3:0] last, logic fr, logic [23:0] pay,
                                logic efv, int eg, logic [3:0] erdy);
        vec_t v;
        v.vld  = vld;
        v.last = last;
        v.fr   = fr;
        v.pay  = pay;
        if (eg < 0) v.exp = {efv, 34'd0, erdy, 1'b0, 2'd0};
        else        v.exp = {efv, 2'(eg), 8'(eg), pay, erdy, 1'b1, 2'(eg)};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_valid  = v.vld;
        req_last   = v.last;
        fifo_ready = v.fr;
        for (int k = 0; k < N; k++) req_data[k*W +: W] = {8'(k), v.pay};
    endtask

    task automatic check(input string nm, input logic [41:0] exp);
        logic [41:0] got;
        got = {fifo_valid, fifo_data, req_ready, busy, grant_idx};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic run(input string nm, input vec_t v);
        drive(v);
        #2 check(nm, v.exp);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        // single requester, then rr pointer steering (req2 beats req0 after req1)
        tbl.push_back(mk(4'b0010, 4'b0000, 1, 24'hA,   0, -1, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 1, 24'hA,   1,  1, 4'b0010));
        tbl.push_back(mk(4'b0010, 4'b0000, 1, 24'hB,   1,  1, 4'b0010));
        tbl.push_back(mk(4'b0010, 4'b0010, 1, 24'hC,   1,  1, 4'b0010));
        tbl.push_back(mk(4'b0101, 4'b0101, 1, 24'hD,   0, -1, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0101, 1, 24'hD,   1,  2, 4'b0100));
        tbl.push_back(mk(4'b0001, 4'b0001, 1, 24'hD,   0, -1, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0001, 1, 24'hD,   1,  0, 4'b0001));
        // round robin, all requesters, 1-beat packets
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h10,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h11,  1,  1, 4'b0010));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h12,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h13,  1,  2, 4'b0100));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h14,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h15,  1,  3, 4'b1000));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h16,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 24'h17,  1,  0, 4'b0001));
        // backpressure: 5 stalled cycles on beat E1 of req3
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 24'hE0,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 24'hE0,  1,  3, 4'b1000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'b1000, 4'b0000, 0, 24'hE1, 1, 3, 4'b0000));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 24'hE1,  1,  3, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b1000, 1, 24'hE2,  1,  3, 4'b1000));
        // owner valid gap while req1 waits
        tbl.push_back(mk(4'b0011, 4'b0010, 1, 24'hF0,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b0011, 4'b0010, 1, 24'hF0,  1,  0, 4'b0001));
        tbl.push_back(mk(4'b0010, 4'b0010, 1, 24'hF1,  0,  0, 4'b0001));
        tbl.push_back(mk(4'b0010, 4'b0010, 1, 24'hF1,  0,  0, 4'b0001));
        tbl.push_back(mk(4'b0011, 4'b0011, 1, 24'hF1,  1,  0, 4'b0001));
        tbl.push_back(mk(4'b0010, 4'b0010, 1, 24'hF2,  0, -1, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0010, 1, 24'hF2,  1,  1, 4'b0010));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 24'h0,   0, -1, 4'b0000));

        rst = 1'b1;
        drive(mk(4'b1111, 4'b1111, 1, 24'h0, 0, -1, 4'b0000));
        repeat (2) @(posedge clk);
        #1 check("reset_state", 42'd0);
        rst = 1'b0;

        foreach (tbl[i]) run($sformatf("tbl[%0d]", i), tbl[i]);

`ifdef CDC_FIFO_ARB_STATS_EN
        total++;
        if (stall_cnt !== 16'd5) begin
            bad++;
            $display("FAIL stall_cnt got=%0d exp=5", stall_cnt);
        end
        total++;
        if (hs_err !== 1'b0) begin
            bad++;
            $display("FAIL hs_err got=%0b exp=0", hs_err);
        end
`endif

        // burst cap: req0 10 beats vs req2 waiting -> 8 from req0, req2, then 2 from req0
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run("cap_idle0", mk(4'b0101, 4'b0100, 1, 24'h0, 0, -1, 4'b0000));
        for (int b = 1; b <= 8; b++)
            run($sformatf("cap_beat%0d", b), mk(4'b0101, 4'b0100, 1, 24'(b), 1, 0, 4'b0001));
        run("cap_idle1",  mk(4'b0101, 4'b0100, 1, 24'h9, 0, -1, 4'b0000));
        run("cap_req2",   mk(4'b0101, 4'b0100, 1, 24'h9, 1,  2, 4'b0100));
        run("cap_idle2",  mk(4'b0001, 4'b0000, 1, 24'h9, 0, -1, 4'b0000));
        run("cap_beat9",  mk(4'b0001, 4'b0000, 1, 24'h9, 1,  0, 4'b0001));
        run("cap_beat10", mk(4'b0001, 4'b0001, 1, 24'hA, 1,  0, 4'b0001));

        // reset mid-burst: req1 owns (rr_ptr=1), async reset after beat 2, req0 then wins
        run("rst_idle",  mk(4'b0011, 4'b0000, 1, 24'h40, 0, -1, 4'b0000));
        run("rst_beat1", mk(4'b0011, 4'b0000, 1, 24'h41, 1,  1, 4'b0010));
        run("rst_beat2", mk(4'b0011, 4'b0000, 1, 24'h42, 1,  1, 4'b0010));
        drive(mk(4'b0011, 4'b0000, 1, 24'h43, 1, 1, 4'b0010));
        #1 rst = 1'b1;
        #1 check("rst_async", 42'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run("rst_after_idle",  mk(4'b0011, 4'b0000, 1, 24'h50, 0, -1, 4'b0000));
        run("rst_after_grant", mk(4'b0011, 4'b0000, 1, 24'h50, 1,  0, 4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
